// File: rtl/eh2_pkg.sv
// Shared LSU definitions for the DCCM ECC scrub path.
//   eh2_scrub_entry_t : one correction write (bank addresses, corrected data,
//                       per-bank write enables).
//   SCRUB_Q_DEPTH_DEFAULT : default depth of the correction queue.
// The entry struct is sized for a 16-bit DCCM byte address and 32-bit banks;
// the top-level DCCM_BITS / DCCM_DATA_WIDTH parameters must stay at these values.
package eh2_pkg;

    localparam int unsigned SCRUB_DATA_W          = 32;
    localparam int unsigned SCRUB_ADDR_W          = 16;
    localparam int unsigned SCRUB_Q_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [SCRUB_ADDR_W-1:0] addr_lo;
        logic [SCRUB_ADDR_W-1:0] addr_hi;
        logic [SCRUB_DATA_W-1:0] data_lo;
        logic [SCRUB_DATA_W-1:0] data_hi;
        logic                    en_lo;
        logic                    en_hi;
    } eh2_scrub_entry_t;

endpackage

// File: rtl/eh2_lsu_scrub_fifo.sv
// Synchronous FIFO of scrub entries.
//   clk, rst_l : clock, asynchronous active-low reset
//   push       : write wr_data (ignored when full unless pop is also asserted)
//   pop        : release the head entry (ignored when empty)
//   rd_data    : head entry, combinational
//   count      : number of stored entries (0..DEPTH)
//   full/empty : derived from count
module eh2_lsu_scrub_fifo
    import eh2_pkg::*;
#(
    parameter int unsigned DEPTH = SCRUB_Q_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       push,
    input  logic                       pop,
    input  eh2_scrub_entry_t           wr_data,
    output eh2_scrub_entry_t           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    eh2_scrub_entry_t mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A push into a full queue is accepted only when the head leaves the
    // same cycle; the slot written is the one being vacated.
    assign do_rd = pop & ~empty;
    assign do_wr = push & (~full | do_rd);

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/eh2_lsu_ecc_scrub.sv
// LSU DCCM ECC scrubber.
// Captures single-bit-error corrected load data in dc3, carries it through
// dc4/dc5, queues one correction per event and writes it back to the DCCM
// banks when the write arbiter grants the scrub slot.
//   inputs  : dc3 ECC status, corrected data, start/end address, arbiter grant,
//             counter clear, scan_mode (clock-gating only, unused here)
//   outputs : scrub write request/enables/addresses/data (queue head),
//             dc1 read stall, saturating SEC counter, sticky overflow flag
module eh2_lsu_ecc_scrub
    import eh2_pkg::*;
#(
    parameter int unsigned DCCM_DATA_WIDTH = SCRUB_DATA_W,
    parameter int unsigned DCCM_BITS       = SCRUB_ADDR_W,
    parameter int unsigned SCRUB_Q_DEPTH   = SCRUB_Q_DEPTH_DEFAULT,
    parameter int unsigned ERR_CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       scan_mode,
    input  logic                       ldst_valid_dc3,
    input  logic                       single_ecc_error_lo_dc3,
    input  logic                       single_ecc_error_hi_dc3,
    input  logic                       double_ecc_error_dc3,
    input  logic [DCCM_DATA_WIDTH-1:0] sec_data_lo_dc3,
    input  logic [DCCM_DATA_WIDTH-1:0] sec_data_hi_dc3,
    input  logic [DCCM_BITS-1:0]       lsu_addr_dc3,
    input  logic [DCCM_BITS-1:0]       end_addr_dc3,
    input  logic                       scrub_wr_gnt,
    input  logic                       err_cnt_clr,
    output logic                       scrub_wr_req,
    output logic                       scrub_wr_en_lo,
    output logic                       scrub_wr_en_hi,
    output logic [DCCM_BITS-1:0]       scrub_wr_addr_lo,
    output logic [DCCM_BITS-1:0]       scrub_wr_addr_hi,
    output logic [DCCM_DATA_WIDTH-1:0] scrub_wr_data_lo,
    output logic [DCCM_DATA_WIDTH-1:0] scrub_wr_data_hi,
    output logic                       scrub_stall,
    output logic [ERR_CNT_WIDTH-1:0]   single_err_cnt,
    output logic                       scrub_overflow
);

    localparam int unsigned CW = $clog2(SCRUB_Q_DEPTH) + 1;

    logic             cap_dc3;
    eh2_scrub_entry_t entry_dc3;
    eh2_scrub_entry_t entry_dc4;
    eh2_scrub_entry_t entry_dc5;
    logic             valid_dc4;
    logic             valid_dc5;

    eh2_scrub_entry_t head;
    logic [CW-1:0]    q_count;
    logic             q_full;
    logic             q_empty;
    logic             q_pop;
    logic             overflow_evt;

    logic [CW-1:0]    free_cnt;
    logic [CW-1:0]    inflight;

    logic [4:0]       unused_bits;
    assign unused_bits = {scan_mode, lsu_addr_dc3[1:0], end_addr_dc3[1:0]};

    // A DED anywhere in the access makes the corrected data untrustworthy,
    // so the whole event is dropped.
    assign cap_dc3 = ldst_valid_dc3
                   & (single_ecc_error_lo_dc3 | single_ecc_error_hi_dc3)
                   & ~double_ecc_error_dc3;

    always_comb begin
        entry_dc3         = '0;
        entry_dc3.addr_lo = {lsu_addr_dc3[DCCM_BITS-1:2], 2'b00};
        entry_dc3.addr_hi = {end_addr_dc3[DCCM_BITS-1:2], 2'b00};
        entry_dc3.data_lo = sec_data_lo_dc3;
        entry_dc3.data_hi = sec_data_hi_dc3;
        entry_dc3.en_lo   = single_ecc_error_lo_dc3;
        entry_dc3.en_hi   = single_ecc_error_hi_dc3;
    end

    // Pipe valids are never flushed: the memory holds bad data regardless
    // of what happens to the instruction.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            valid_dc4 <= 1'b0;
            valid_dc5 <= 1'b0;
        end else begin
            valid_dc4 <= cap_dc3;
            valid_dc5 <= valid_dc4;
        end
    end

    // Payload flops load only with their stage valid (rvdffe-style gating).
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            entry_dc4 <= '0;
        end else if (cap_dc3) begin
            entry_dc4 <= entry_dc3;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            entry_dc5 <= '0;
        end else if (valid_dc4) begin
            entry_dc5 <= entry_dc4;
        end
    end

    eh2_lsu_scrub_fifo #(
        .DEPTH (SCRUB_Q_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .push    (valid_dc5),
        .pop     (q_pop),
        .wr_data (entry_dc5),
        .rd_data (head),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    assign scrub_wr_req = ~q_empty;
    assign q_pop        = scrub_wr_req & scrub_wr_gnt;
    assign overflow_evt = valid_dc5 & q_full & ~q_pop;

    // Head fields are masked when the queue is empty so stale entries never
    // appear on the write port.
    always_comb begin
        scrub_wr_en_lo   = 1'b0;
        scrub_wr_en_hi   = 1'b0;
        scrub_wr_addr_lo = '0;
        scrub_wr_addr_hi = '0;
        scrub_wr_data_lo = '0;
        scrub_wr_data_hi = '0;
        if (scrub_wr_req) begin
            scrub_wr_en_lo   = head.en_lo;
            scrub_wr_en_hi   = head.en_hi;
            scrub_wr_addr_lo = head.addr_lo;
            scrub_wr_addr_hi = head.addr_hi;
            scrub_wr_data_lo = head.data_lo;
            scrub_wr_data_hi = head.data_hi;
        end
    end

    // Reserve a slot for every event already in dc4/dc5 plus one more for
    // the access that may still be in dc3 when the stall takes effect.
    assign free_cnt    = CW'(SCRUB_Q_DEPTH) - q_count;
    assign inflight    = CW'(valid_dc4) + CW'(valid_dc5) + CW'(1);
    assign scrub_stall = (free_cnt <= inflight);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            single_err_cnt <= '0;
            scrub_overflow <= 1'b0;
        end else if (err_cnt_clr) begin
            single_err_cnt <= '0;
            scrub_overflow <= 1'b0;
        end else begin
            if (valid_dc5 && (single_err_cnt != '1)) begin
                single_err_cnt <= single_err_cnt + 1'b1;
            end
            if (overflow_evt) begin
                scrub_overflow <= 1'b1;
            end
        end
    end

endmodule
